// File: rtl/reg_slice_full.sv
// Fully registered valid/ready slice: main+skid buffer so that valid, data,
// ready and level all come straight from flops, cutting both directions.
module reg_slice_full #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] up_data,
    input  logic              up_valid,
    output logic              up_ready,
    output logic [DATA_W-1:0] down_data,
    output logic              down_valid,
    input  logic              down_ready,
    input  logic              flush,
    output logic [1:0]        level,
    output logic [CNT_W-1:0]  beat_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2,
        BAD   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] main_reg;
    logic [DATA_W-1:0] skid_reg;
    logic              valid_reg;
    logic              ready_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic push;
    logic pop;
    logic load_main_up;
    logic load_main_skid;
    logic load_skid;

    assign push = up_valid & ready_reg;
    assign pop  = valid_reg & down_ready;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next     = state;
        load_main_up   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        load_main_up = 1'b1;
                        state_next   = HALF;
                    end
                end
                HALF: begin
                    if (push && pop) begin
                        load_main_up = 1'b1;
                    end else if (push) begin
                        load_skid  = 1'b1;
                        state_next = FULL;
                    end else if (pop) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        load_main_skid = 1'b1;
                        state_next     = HALF;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
            main_reg  <= '0;
            skid_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state <= state_next;
            // Handshake flags are decoded from the next state so they stay pure flop outputs.
            valid_reg <= (state_next == HALF) || (state_next == FULL);
            ready_reg <= (state_next != FULL);
            if (load_main_up) begin
                main_reg <= up_data;
            end else if (load_main_skid) begin
                main_reg <= skid_reg;
            end
            if (load_skid) begin
                skid_reg <= up_data;
            end
            if (pop) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign level      = state;
    assign down_valid = valid_reg;
    assign up_ready   = ready_reg;
    assign down_data  = main_reg;
    assign beat_cnt   = cnt_reg;

endmodule

// File: tb/tb_reg_slice_full.sv
// Bench for reg_slice_full: directed vectors plus a random phase, with a
// reference occupancy model feeding an expected-data queue checked by a monitor.
module tb_reg_slice_full;

    logic        clk;
    logic        rst_n;
    logic [7:0]  up_data;
    logic        up_valid;
    logic        down_ready;
    logic        flush;

    logic        up_ready;
    logic [7:0]  down_data;
    logic        down_valid;
    logic [1:0]  level;
    logic [15:0] beat_cnt;

    logic        up_ready_s;
    logic [7:0]  down_data_s;
    logic        down_valid_s;
    logic [1:0]  level_s;
    logic [3:0]  beat_cnt_s;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q[$];
    logic [1:0]  model_level = 2'd0;
    logic [15:0] exp_cnt = 16'd0;
    logic        stall_prev = 1'b0;
    logic [7:0]  prev_data = 8'd0;
    logic        m_push;
    logic        m_pop;
    logic [15:0] cnt0;

    reg_slice_full #(.DATA_W(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .up_data(up_data), .up_valid(up_valid),
        .up_ready(up_ready), .down_data(down_data), .down_valid(down_valid),
        .down_ready(down_ready), .flush(flush), .level(level), .beat_cnt(beat_cnt)
    );

    // Second instance shares all stimulus to exercise a narrow wrapping counter.
    reg_slice_full #(.DATA_W(8), .CNT_W(4)) u_small (
        .clk(clk), .rst_n(rst_n), .up_data(up_data), .up_valid(up_valid),
        .up_ready(up_ready_s), .down_data(down_data_s), .down_valid(down_valid_s),
        .down_ready(down_ready), .flush(flush), .level(level_s), .beat_cnt(beat_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    assign m_push = up_valid && (model_level != 2'd2) && !flush;
    assign m_pop  = (model_level != 2'd0) && down_ready;

    // Stimulus side: accepted beats go into the expected queue; occupancy model advances.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_level <= 2'd0;
        end else begin
            if (m_push) exp_q.push_back(up_data);
            if (flush) model_level <= 2'd0;
            else model_level <= 2'(int'(model_level) + int'(m_push) - int'(m_pop));
        end
    end

    // Monitor side: compares outputs against the model and pops on each delivery.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt    <= 16'd0;
            stall_prev <= 1'b0;
        end else begin
            check("level", 32'(level), 32'(model_level));
            check("small_level", 32'(level_s), 32'(model_level));
            check("down_valid", 32'(down_valid), 32'(model_level != 2'd0));
            check("up_ready", 32'(up_ready), 32'(model_level != 2'd2));
            check("beat_cnt", 32'(beat_cnt), 32'(exp_cnt));
            check("beat_cnt_small", 32'(beat_cnt_s), 32'(exp_cnt[3:0]));
            if (stall_prev) check("stall_stable", 32'(down_data), 32'(prev_data));
            if (m_pop) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_underflow: got 0x%0h expected no beat at %0t", down_data, $time);
                end else begin
                    check("down_data", 32'(down_data), 32'(exp_q.pop_front()));
                end
                exp_cnt <= exp_cnt + 16'd1;
            end
            if (flush) exp_q.delete();
            stall_prev <= (model_level != 2'd0) && !down_ready && !flush;
            prev_data  <= down_data;
        end
    end

    initial begin
        rst_n      = 1'b0;
        up_data    = 8'h00;
        up_valid   = 1'b0;
        down_ready = 1'b0;
        flush      = 1'b0;
        repeat (2) step();
        check("rst_level", 32'(level), 32'd0);
        check("rst_valid", 32'(down_valid), 32'd0);
        check("rst_ready", 32'(up_ready), 32'd1);
        check("rst_data", 32'(down_data), 32'd0);
        check("rst_cnt", 32'(beat_cnt), 32'd0);
        rst_n = 1'b1;
        step();

        // Streaming 0x01..0x10 with no bubbles.
        for (int i = 1; i <= 16; i++) begin
            up_valid = 1'b1; up_data = 8'(i); down_ready = 1'b1;
            step();
            check("stream_data", 32'(down_data), 32'(i));
            check("stream_level", 32'(level), 32'd1);
        end
        up_valid = 1'b0;
        step();
        check("stream_cnt", 32'(beat_cnt), 32'd16);
        check("stream_cnt_small", 32'(beat_cnt_s), 32'd0);
        check("stream_empty", 32'(level), 32'd0);

        // Stall: A0 in main, A1 in skid, A2 held off.
        up_valid = 1'b1; up_data = 8'hA0; down_ready = 1'b1;
        step();
        check("stall_a0", 32'(down_data), 32'hA0);
        down_ready = 1'b0; up_data = 8'hA1;
        step();
        check("stall_full", 32'(level), 32'd2);
        check("stall_noready", 32'(up_ready), 32'd0);
        check("stall_main", 32'(down_data), 32'hA0);
        check("stall_skid", 32'(u_dut.skid_reg), 32'hA1);
        up_data = 8'hA2;
        step();
        check("stall_hold_lvl", 32'(level), 32'd2);
        check("stall_hold_data", 32'(down_data), 32'hA0);
        down_ready = 1'b1;
        step();
        check("release_a1", 32'(down_data), 32'hA1);
        check("release_ready", 32'(up_ready), 32'd1);
        step();
        check("release_a2", 32'(down_data), 32'hA2);
        up_valid = 1'b0;
        step();
        check("release_empty", 32'(level), 32'd0);

        // Flush from FULL with simultaneous pop and push.
        up_valid = 1'b1; up_data = 8'hB0; down_ready = 1'b0;
        step();
        up_data = 8'hB1;
        step();
        check("flush_pre_full", 32'(level), 32'd2);
        cnt0 = beat_cnt;
        flush = 1'b1; down_ready = 1'b1; up_data = 8'hB2;
        step();
        check("flush_level", 32'(level), 32'd0);
        check("flush_cnt", 32'(beat_cnt), 32'(cnt0 + 16'd1));
        flush = 1'b0; up_valid = 1'b0;
        step();
        check("flush_still_empty", 32'(down_valid), 32'd0);
        up_valid = 1'b1; up_data = 8'hC0;
        step();
        check("post_flush_c0", 32'(down_data), 32'hC0);
        up_valid = 1'b0;
        step();

        // Asynchronous reset while FULL.
        up_valid = 1'b1; up_data = 8'hD0; down_ready = 1'b0;
        step();
        up_data = 8'hD1;
        step();
        check("prereset_full", 32'(level), 32'd2);
        rst_n = 1'b0;
        #1;
        check("async_level", 32'(level), 32'd0);
        check("async_valid", 32'(down_valid), 32'd0);
        check("async_ready", 32'(up_ready), 32'd1);
        check("async_cnt", 32'(beat_cnt), 32'd0);
        up_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Counter wrap on the 4-bit instance: 17 pops.
        for (int i = 0; i < 17; i++) begin
            up_valid = 1'b1; up_data = 8'(8'h40 + i); down_ready = 1'b1;
            step();
        end
        up_valid = 1'b0;
        step();
        check("wrap_small", 32'(beat_cnt_s), 32'd1);
        check("wrap_big", 32'(beat_cnt), 32'd17);

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            up_valid   = 1'($urandom_range(0, 1));
            down_ready = 1'($urandom_range(0, 1));
            up_data    = 8'($urandom);
            step();
        end
        up_valid = 1'b0; down_ready = 1'b1;
        repeat (4) step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_slice_full.md
# reg_slice_full

Fully registered valid/ready pipeline stage for a DATA_W-bit stream. Every output is driven directly from a flop: `down_valid` and `down_data` come from a main register, and `up_ready` comes from a registered occupancy state. There is no combinational path from either side to the other. It sits on long or congested stream links where both the forward (valid/data) and backward (ready) paths must be cut. It uses a 2-entry main+skid buffer to sustain one beat per cycle.

## Interface
- DATA_W, default 8: stream payload width.
- CNT_W, default 16: width of the delivered-beat counter.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- up_data  input  DATA_W  upstream payload.
- up_valid  input  1  upstream beat present.
- up_ready  output  1  slice can accept a beat; registered.
- down_data  output  DATA_W  downstream payload; registered.
- down_valid  output  1  downstream beat present; registered.
- down_ready  input  1  downstream accepts a beat.
- flush  input  1  synchronous clear of buffered contents.
- level  output  2  current occupancy, 0..2; registered.
- beat_cnt  output  CNT_W  count of downstream handshakes; wraps modulo 2^CNT_W.

## Operation
- Handshake terms:
  - push = up_valid & up_ready.
  - pop = down_valid & down_ready.
  - A beat transfers on a rising edge where push or pop is high.
- Storage:
  - main_reg always holds the oldest beat.
  - skid_reg holds the second beat.
  - Data order is strictly FIFO.
- States (encoded as level):
  - EMPTY (0): down_valid=0, up_ready=1.
  - HALF (1): down_valid=1, up_ready=1.
  - FULL (2): down_valid=1, up_ready=0.
- Transitions from EMPTY:
  - push: main_reg<=up_data, go to HALF.
  - no push: stay in EMPTY.
- Transitions from HALF:
  - push&pop: main_reg<=up_data, stay in HALF.
  - push only: skid_reg<=up_data, go to FULL.
  - pop only: go to EMPTY.
  - neither: stay in HALF, all registers hold.
- Transitions from FULL:
  - pop: main_reg<=skid_reg, go to HALF.
  - no pop: stay in FULL.
  - push cannot occur, because up_ready=0.
- Outputs are pure state decodes:
  - down_valid = (level!=0).
  - up_ready = (level!=2).
  - down_data = main_reg.
- beat_cnt increments by 1 on every pop, wraps from 2^CNT_W-1 to 0, and is unaffected by flush.
- flush has highest priority:
  - Next state is EMPTY regardless of push or pop.
  - A beat pushed in the flush cycle is discarded.
  - A pop in the flush cycle is still a valid delivery and is counted.
- While down_valid=1, main_reg must not change unless pop or flush occurs.
- down_data is held stable while down_valid=1 and down_ready=0.
- Out-of-range level value 3 is unreachable; if entered, the next edge goes to EMPTY.

## Timing
- Reset values, applied asynchronously:
  - level=0, down_valid=0, up_ready=1.
  - down_data=0, skid_reg=0, beat_cnt=0.
- Reset is released synchronously into EMPTY. Reset during operation discards all buffered beats.
- Latency: a beat pushed at edge N is visible on down_data/down_valid after edge N, i.e. in cycle N+1.
- Throughput: 1 beat per cycle sustained when down_ready=1 continuously.
- Backpressure:
  - down_ready low for 1 cycle while streaming: the slice absorbs one extra beat into skid_reg, goes to FULL, and drops up_ready in the next cycle.
  - No beat is lost or duplicated.
- Recovery from FULL: after the first pop, up_ready rises in the following cycle.
- up_valid and up_data may change freely while up_ready=0; those values are ignored.

## Test plan
- Reset: assert rst_n=0 mid-stream with level=2 → level=0, down_valid=0, up_ready=1, beat_cnt=0 immediately, without waiting for a clock edge.
- Streaming:
  - Stimulus: up_valid=1 with data 0x01..0x10 on consecutive cycles, down_ready=1.
  - Required: down_data shows 0x01..0x10 one cycle later, with no bubbles.
  - Required: level stays at 1 and beat_cnt=16 at the end.
- Stall:
  - Stimulus: stream 0xA0,0xA1,0xA2 with down_ready=0 starting in the cycle 0xA0 is first presented downstream.
  - Required: 0xA0 is in main_reg, 0xA1 is in skid_reg, up_ready=0, and 0xA2 is held off.
  - Then release down_ready → order 0xA0,0xA1,0xA2 delivered.
- Flush:
  - Stimulus: with level=2, assert flush together with down_ready=1 and up_valid=1 for one cycle.
  - Required: next level=0 and beat_cnt+1.
  - Required: the incoming beat and the skid beat never appear downstream.
- Counter wrap:
  - Setup: CNT_W=4.
  - Stimulus: 17 pops.
  - Required: beat_cnt reads 1.
- Random: random up_valid/down_ready at 50% each over 10k cycles. Against a scoreboard, require:
  - in-order, lossless delivery;
  - down_data stable while stalled;
  - up_ready==(level!=2) every cycle.
